// File: rtl/hall_emulator.sv
// Hall-sensor pattern generator: steps a six-sector electrical sequence at a
// programmable period and direction, emitting the matching 120-degree Hall code.
module hall_emulator #(
  parameter int CNT_WIDTH = 24,
  parameter int REV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 forward,
  input  logic [CNT_WIDTH-1:0] step_period,
  output logic                 hall_a,
  output logic                 hall_b,
  output logic                 hall_c,
  output logic [2:0]           sector,
  output logic                 step_strobe,
  output logic [REV_WIDTH-1:0] rev_count,
  output logic                 stalled
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_per_sh;
  logic                 r_dir_sh;
  logic [2:0]           r_sector;
  logic [2:0]           r_hall;
  logic                 r_step_strobe;
  logic [REV_WIDTH-1:0] r_rev_count;
  logic                 r_stalled;

  logic                 w_per_zero;
  logic                 w_run;
  logic                 w_tc;
  logic                 w_load;
  logic                 w_wrap;
  logic [2:0]           w_next_sector;

  function automatic logic [2:0] hall_code(input logic [2:0] s);
    case (s)
      3'd0:    hall_code = 3'b100;
      3'd1:    hall_code = 3'b110;
      3'd2:    hall_code = 3'b010;
      3'd3:    hall_code = 3'b011;
      3'd4:    hall_code = 3'b001;
      3'd5:    hall_code = 3'b101;
      default: hall_code = 3'b100;
    endcase
  endfunction

  assign w_per_zero = (r_per_sh == '0);
  assign w_run      = enable & ~w_per_zero;
  assign w_tc       = w_run & (r_cnt == r_per_sh - CNT_WIDTH'(1));
  // Shadows only track the inputs at step boundaries, so a step never changes
  // length or direction once it has started.
  assign w_load     = ~enable | w_per_zero | w_tc;
  assign w_wrap     = r_dir_sh ? (r_sector == 3'd5) : (r_sector == 3'd0);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next_sector = r_sector;
    if (r_dir_sh) w_next_sector = (r_sector == 3'd5) ? 3'd0 : r_sector + 3'd1;
    else          w_next_sector = (r_sector == 3'd0) ? 3'd5 : r_sector - 3'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt         <= '0;
      r_per_sh      <= '0;
      r_dir_sh      <= 1'b1;
      r_sector      <= 3'd0;
      r_hall        <= 3'b100;
      r_step_strobe <= 1'b0;
      r_rev_count   <= '0;
      r_stalled     <= 1'b0;
    end else begin
      if (w_load) begin
        r_per_sh <= step_period;
        r_dir_sh <= forward;
      end
      if (!w_run || w_tc) r_cnt <= '0;
      else                r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (w_tc) begin
        r_sector <= w_next_sector;
        r_hall   <= hall_code(w_next_sector);
        if (w_wrap) r_rev_count <= r_rev_count + REV_WIDTH'(1);
      end
      r_step_strobe <= w_tc;
      r_stalled     <= enable & w_per_zero;
    end
  end

  assign hall_a      = r_hall[2];
  assign hall_b      = r_hall[1];
  assign hall_c      = r_hall[0];
  assign sector      = r_sector;
  assign step_strobe = r_step_strobe;
  assign rev_count   = r_rev_count;
  assign stalled     = r_stalled;

endmodule

// File: tb/tb_hall_emulator.sv
// Bench for hall_emulator: directed test-plan sequences plus random stimulus,
// all checked by a cycle scoreboard fed from a sector/step-count reference model.
module tb_hall_emulator;
  localparam int CW = 24;
  localparam int RW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          forward = 1'b1;
  logic [CW-1:0] step_period = '0;
  logic          hall_a, hall_b, hall_c;
  logic [2:0]    sector;
  logic          step_strobe;
  logic [RW-1:0] rev_count;
  logic          stalled;

  hall_emulator #(.CNT_WIDTH(CW), .REV_WIDTH(RW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .forward(forward),
    .step_period(step_period), .hall_a(hall_a), .hall_b(hall_b), .hall_c(hall_c),
    .sector(sector), .step_strobe(step_strobe), .rev_count(rev_count), .stalled(stalled)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sector as an integer 0..5, elapsed cycles within the
  // current step, and the period/direction that govern that step.
  int hall_tab[6] = '{4, 6, 2, 3, 1, 5};
  int m_sector = 0, m_rev = 0, m_per = 0, m_dir = 1, m_elapsed = 0;
  int m_strobe = 0, m_stalled = 0;
  bit m_run, m_step;
  logic [31:0] sb_q[$];

  always @(posedge clock) begin
    if (reset) begin
      m_sector = 0; m_rev = 0; m_per = 0; m_dir = 1; m_elapsed = 0;
      m_strobe = 0; m_stalled = 0;
    end else begin
      m_run     = enable && (m_per != 0);
      m_step    = m_run && (m_elapsed + 1 == m_per);
      m_stalled = (enable && m_per == 0) ? 1 : 0;
      m_strobe  = m_step ? 1 : 0;
      if (m_step) begin
        if (m_dir != 0) begin
          m_sector = (m_sector + 1) % 6;
          if (m_sector == 0) m_rev = (m_rev + 1) % 65536;
        end else begin
          if (m_sector == 0) m_rev = (m_rev + 1) % 65536;
          m_sector = (m_sector + 5) % 6;
        end
        m_elapsed = 0;
      end else begin
        m_elapsed = m_run ? m_elapsed + 1 : 0;
      end
      if (!enable || m_per == 0 || m_step) begin
        m_per = int'(step_period);
        m_dir = forward ? 1 : 0;
      end
    end
    sb_q.push_back(32'((m_rev << 12) | (m_sector << 8) | (hall_tab[m_sector] << 4)
                       | (m_strobe << 1) | m_stalled));
  end

  // Monitor: one registered snapshot per clock, compared on the falling edge.
  logic [31:0] sb_exp;
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      sb_exp = sb_q.pop_front();
      check("scoreboard", 32'({rev_count, 1'b0, sector, 1'b0, hall_a, hall_b, hall_c,
                               2'b00, step_strobe, stalled}), sb_exp);
    end
  end

  function automatic logic [2:0] hall_now();
    return {hall_a, hall_b, hall_c};
  endfunction

  int fwd_codes[6] = '{6, 2, 3, 1, 5, 4};

  initial begin
    // Reset held two cycles with random inputs.
    @(negedge clock);
    reset = 1'b1;
    enable = 1'($urandom);
    forward = 1'($urandom);
    step_period = CW'($urandom_range(0, 9));
    repeat (2) @(negedge clock);
    check("reset_hall", 32'(hall_now()), 32'd4);
    check("reset_sector", 32'(sector), 32'd0);
    check("reset_rev", 32'(rev_count), 32'd0);
    check("reset_strobe", 32'(step_strobe), 32'd0);
    check("reset_stalled", 32'(stalled), 32'd0);

    // Forward run, P=4: period latched while idle, then enable rises.
    reset = 1'b0; enable = 1'b0; forward = 1'b1; step_period = CW'(4);
    @(negedge clock);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      repeat (3) @(negedge clock);
      check("fwd_no_strobe", 32'(step_strobe), 32'd0);
      @(negedge clock);
      check("fwd_strobe", 32'(step_strobe), 32'd1);
      check("fwd_hall", 32'(hall_now()), 32'(fwd_codes[k]));
    end
    check("fwd_rev", 32'(rev_count), 32'd1);

    // Reverse wrap from sector 0 with P=3.
    enable = 1'b0; forward = 1'b0; step_period = CW'(3);
    @(negedge clock);
    enable = 1'b1;
    repeat (3) @(negedge clock);
    check("rev_hall1", 32'(hall_now()), 32'd5);
    check("rev_rev1", 32'(rev_count), 32'd2);
    repeat (3) @(negedge clock);
    check("rev_hall2", 32'(hall_now()), 32'd1);
    check("rev_rev2", 32'(rev_count), 32'd2);

    // Stall for 100 cycles, then a nonzero period.
    enable = 1'b0; step_period = '0;
    @(negedge clock);
    enable = 1'b1;
    repeat (100) @(negedge clock);
    check("stall_flag", 32'(stalled), 32'd1);
    check("stall_hall", 32'(hall_now()), 32'd1);
    step_period = CW'(5);
    @(negedge clock);
    repeat (4) @(negedge clock);
    check("unstall_wait", 32'(step_strobe), 32'd0);
    @(negedge clock);
    check("unstall_strobe", 32'(step_strobe), 32'd1);
    check("unstall_sector", 32'(sector), 32'd3);

    // Enable drop mid-step discards the partial step.
    repeat (2) @(negedge clock);
    enable = 1'b0;
    repeat (10) @(negedge clock);
    check("frozen_sector", 32'(sector), 32'd3);
    enable = 1'b1;
    repeat (4) @(negedge clock);
    check("reen_wait", 32'(step_strobe), 32'd0);
    @(negedge clock);
    check("reen_strobe", 32'(step_strobe), 32'd1);
    check("reen_sector", 32'(sector), 32'd2);

    // Random traffic, including mid-step period/direction changes and resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      if ($urandom_range(0, 14) == 0) forward = ~forward;
      if ($urandom_range(0, 9) == 0) step_period = CW'($urandom_range(0, 7));
    end

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
